// File: rtl/cordic_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cordic_rr_arbiter
//
// Shares one iterative CORDIC sine/cosine core among NREQ requesters. It picks
// one pending request in round-robin order, runs it on the core, captures the
// cosine/sine result (or a timeout error) and hands it back to the requester
// that was granted. At most one operation is in flight at any time.
//
// Parameters
//   NREQ     number of requesters (2..16)
//   DW       angle / result width
//   TIMEOUT  cycles to wait for core_done after core_start (>= 2)
//
// Ports
//   aclk        clock, all logic on the rising edge
//   areset      synchronous active-high reset
//   req_valid   per-requester request valid
//   req_ready   per-requester accept, one-hot or zero, only in IDLE
//   req_angle   packed angles, requester i at [i*DW +: DW]
//   rsp_valid   per-requester response valid, one-hot or zero (registered)
//   rsp_ready   per-requester response accept (only the granted bit matters)
//   rsp_cos     cosine result, shared by all requesters
//   rsp_sin     sine result, shared by all requesters
//   rsp_err     1 = the response is a timeout and cos/sin are zero
//   grant_id    index of the current / last granted requester
//   busy        high whenever the sequencer is not idle
//   core_start  one-cycle start pulse to the CORDIC core
//   core_angle  angle to the core, stable from start until done
//   core_done   single-cycle result-valid pulse from the core
//   core_cos    core cosine output, sampled on core_done
//   core_sin    core sine output, sampled on core_done
// ---------------------------------------------------------------------------
module cordic_rr_arbiter #(
  parameter  int NREQ    = 4,
  parameter  int DW      = 32,
  parameter  int TIMEOUT = 64,
  localparam int GW      = $clog2(NREQ)
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_angle,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [DW-1:0]      rsp_cos,
  output logic [DW-1:0]      rsp_sin,
  output logic               rsp_err,
  output logic [GW-1:0]      grant_id,
  output logic               busy,
  output logic               core_start,
  output logic [DW-1:0]      core_angle,
  input  logic               core_done,
  input  logic [DW-1:0]      core_cos,
  input  logic [DW-1:0]      core_sin
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_RESP
  } state_e;

  state_e            state_q;
  logic [GW-1:0]     ptr_q;
  logic [GW-1:0]     grant_id_q;
  logic [DW-1:0]     core_angle_q;
  logic              core_start_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [DW-1:0]     rsp_cos_q;
  logic [DW-1:0]     rsp_sin_q;
  logic              rsp_err_q;
  logic [CW-1:0]     cnt_q;

  logic [DW-1:0]     angle_arr [NREQ];
  logic              arb_found;
  logic [GW-1:0]     arb_idx;
  logic [GW-1:0]     cand;

  function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign angle_arr[g] = req_angle[g*DW +: DW];
  end

  // Round-robin search: walk from ptr+1 upward, wrapping at NREQ-1 (NREQ need
  // not be a power of two, so the wrap is explicit rather than by overflow).
  // NOTE: every signal written here gets a default before the loop; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      cand = (cand == GW'(NREQ - 1)) ? '0 : cand + 1'b1;
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Accept is combinational so the requester sees it in the same cycle the
  // sequencer samples its angle; it is masked during reset.
  assign req_ready  = (state_q == S_IDLE && arb_found && !areset) ? onehot(arb_idx) : '0;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_id_q;
  assign core_angle = core_angle_q;
  assign core_start = core_start_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_cos    = rsp_cos_q;
  assign rsp_sin    = rsp_sin_q;
  assign rsp_err    = rsp_err_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      // ptr starts at NREQ-1 so requester 0 wins the first arbitration.
      state_q      <= S_IDLE;
      ptr_q        <= GW'(NREQ - 1);
      grant_id_q   <= '0;
      core_angle_q <= '0;
      core_start_q <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_cos_q    <= '0;
      rsp_sin_q    <= '0;
      rsp_err_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      core_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arb_found) begin
            core_angle_q <= angle_arr[arb_idx];
            grant_id_q   <= arb_idx;
            core_start_q <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          // A done arriving on the timeout cycle still counts as a result.
          if (core_done) begin
            rsp_cos_q   <= core_cos;
            rsp_sin_q   <= core_sin;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= onehot(grant_id_q);
            state_q     <= S_RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rsp_cos_q   <= '0;
            rsp_sin_q   <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= onehot(grant_id_q);
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready[grant_id_q]) begin
            ptr_q       <= grant_id_q;
            rsp_valid_q <= '0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cordic_rr_arbiter
//
// Directed bench for cordic_rr_arbiter (NREQ=4, DW=32, TIMEOUT=64). A small
// core model answers each core_start after core_lat cycles (0 = never) with
// model_cos/model_sin; manual_done injects stray done pulses. Inputs are
// driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_cordic_rr_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 32;
  localparam int TIMEOUT = 64;
  localparam int GW      = 2;

  logic               aclk;
  logic               areset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_angle;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [DW-1:0]      rsp_cos;
  logic [DW-1:0]      rsp_sin;
  logic               rsp_err;
  logic [GW-1:0]      grant_id;
  logic               busy;
  logic               core_start;
  logic [DW-1:0]      core_angle;
  logic               core_done;
  logic [DW-1:0]      core_cos;
  logic [DW-1:0]      core_sin;

  int          checks;
  int          errors;
  int          core_lat;
  logic        model_done;
  logic        manual_done;
  logic [31:0] model_cos;
  logic [31:0] model_sin;

  assign core_done = model_done | manual_done;
  assign core_cos  = model_cos;
  assign core_sin  = model_sin;

  cordic_rr_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_angle  (req_angle),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_cos    (rsp_cos),
    .rsp_sin    (rsp_sin),
    .rsp_err    (rsp_err),
    .grant_id   (grant_id),
    .busy       (busy),
    .core_start (core_start),
    .core_angle (core_angle),
    .core_done  (core_done),
    .core_cos   (core_cos),
    .core_sin   (core_sin)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Core model: start seen in cycle s -> done high during cycle s+core_lat.
  initial begin
    model_done = 1'b0;
    forever begin
      @(negedge aclk);
      if (core_start === 1'b1 && core_lat > 0) begin
        repeat (core_lat) @(negedge aclk);
        model_done = 1'b1;
        @(negedge aclk);
        model_done = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (core_start !== 1'b1 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    check(tag, core_start, 1);
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (rsp_valid === '0 && n < 200) begin
      @(negedge aclk);
      n++;
    end
    check(tag, (rsp_valid !== '0), 1);
  endtask

  task automatic set_angle(input int idx, input logic [31:0] a);
    req_angle[idx*DW +: DW] = a;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    core_lat    = 32;
    manual_done = 1'b0;
    model_cos   = 32'h5a827999;
    model_sin   = 32'h5a827999;
    areset      = 1'b1;
    req_valid   = 4'b0100;
    rsp_ready   = '0;
    req_angle   = '0;
    set_angle(2, 32'h40000000);

    // ---------------- reset state ----------------
    repeat (3) @(negedge aclk);
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_angle", core_angle, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_cos", rsp_cos, 0);
    check("rst_rsp_err", rsp_err, 0);

    // ---------------- single request, L = 32 ----------------
    areset = 1'b0;
    #1;
    check("single_req_ready", req_ready, 4'b0100);
    @(negedge aclk);                      // cycle T0+1 (ISSUE)
    check("single_ready_one_cycle", req_ready, 4'b0000);
    check("single_core_start", core_start, 1);
    check("single_core_angle", core_angle, 32'h40000000);
    check("single_grant_id", grant_id, 2);
    check("single_busy", busy, 1);
    req_valid = '0;
    for (int k = 2; k <= 33; k++) begin
      @(negedge aclk);
      check("single_wait_no_rsp", rsp_valid, 4'b0000);
      check("single_no_extra_start", core_start, 0);
    end
    @(negedge aclk);                      // cycle T0+34
    check("single_rsp_valid", rsp_valid, 4'b0100);
    check("single_rsp_cos", rsp_cos, 32'h5a827999);
    check("single_rsp_sin", rsp_sin, 32'h5a827999);
    check("single_rsp_err", rsp_err, 0);
    rsp_ready = 4'b0100;
    @(negedge aclk);
    check("single_rsp_done", rsp_valid, 4'b0000);
    check("single_idle", busy, 0);
    rsp_ready = '0;

    // ---------------- fairness from reset ----------------
    areset = 1'b1;
    @(negedge aclk);
    areset    = 1'b0;
    core_lat  = 2;
    model_cos = 32'h0000_1111;
    model_sin = 32'h0000_2222;
    for (int i = 0; i < NREQ; i++) set_angle(i, 32'(i + 1));
    rsp_ready = 4'b1111;
    req_valid = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      wait_start("fair_start_seen");
      check("fair_grant_id", grant_id, 64'(n % 4));
      check("fair_core_angle", core_angle, 64'((n % 4) + 1));
      if (n == 5) req_valid = '0;
      @(negedge aclk);
    end
    repeat (8) @(negedge aclk);
    check("fair_drained", busy, 0);

    // ---------------- backpressure on requester 1 ----------------
    core_lat  = 3;
    model_cos = 32'h0000_1234;
    model_sin = 32'h0000_5678;
    set_angle(1, 32'h11);
    rsp_ready = '0;
    req_valid = 4'b0010;
    wait_rsp("bp_rsp_seen");
    req_valid = 4'b1111;
    rsp_ready = 4'b1101;                  // other bits must be ignored
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      check("bp_rsp_valid", rsp_valid, 4'b0010);
      check("bp_rsp_cos", rsp_cos, 32'h1234);
      check("bp_rsp_sin", rsp_sin, 32'h5678);
      check("bp_grant_id", grant_id, 1);
      check("bp_req_ready", req_ready, 4'b0000);
      check("bp_no_start", core_start, 0);
    end
    req_valid = '0;
    rsp_ready = 4'b1111;
    @(negedge aclk);
    check("bp_released", rsp_valid, 4'b0000);
    rsp_ready = '0;

    // ---------------- timeout ----------------
    core_lat = 0;
    set_angle(0, 32'h77);
    req_valid = 4'b0001;
    wait_start("to_start_seen");
    req_valid = '0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge aclk);
      check("to_no_early_rsp", rsp_valid, 4'b0000);
    end
    @(negedge aclk);                      // TIMEOUT+1 cycles after start
    check("to_rsp_valid", rsp_valid, 4'b0001);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_cos", rsp_cos, 0);
    check("to_rsp_sin", rsp_sin, 0);
    rsp_ready = 4'b0001;
    @(negedge aclk);
    check("to_released", rsp_valid, 4'b0000);
    rsp_ready = '0;

    // next request after a timeout completes normally
    core_lat  = 1;
    model_cos = 32'h0000_aaaa;
    model_sin = 32'h0000_bbbb;
    set_angle(2, 32'h99);
    req_valid = 4'b0100;
    wait_start("post_to_start_seen");
    check("post_to_angle", core_angle, 32'h99);
    req_valid = '0;
    wait_rsp("post_to_rsp_seen");
    check("post_to_rsp_valid", rsp_valid, 4'b0100);
    check("post_to_rsp_err", rsp_err, 0);
    check("post_to_rsp_cos", rsp_cos, 32'haaaa);
    check("post_to_rsp_sin", rsp_sin, 32'hbbbb);
    rsp_ready = 4'b0100;
    @(negedge aclk);
    rsp_ready = '0;

    // ---------------- reset mid-operation ----------------
    core_lat = 10;
    set_angle(3, 32'h33);
    req_valid = 4'b1000;
    wait_start("rmo_start_seen");         // cycle s
    req_valid = '0;
    repeat (2) @(negedge aclk);           // cycle s+2, in BUSY
    check("rmo_in_busy", busy, 1);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    check("rmo_busy", busy, 0);
    check("rmo_grant_id", grant_id, 0);
    check("rmo_core_angle", core_angle, 0);
    check("rmo_core_start", core_start, 0);
    check("rmo_rsp_valid", rsp_valid, 4'b0000);
    check("rmo_rsp_cos", rsp_cos, 0);
    check("rmo_rsp_sin", rsp_sin, 0);
    check("rmo_rsp_err", rsp_err, 0);
    check("rmo_req_ready", req_ready, 4'b0000);
    for (int k = 0; k < 10; k++) begin    // late core_done lands in here
      @(negedge aclk);
      check("rmo_late_done_busy", busy, 0);
      check("rmo_late_done_rsp", rsp_valid, 4'b0000);
    end
    core_lat  = 2;
    model_cos = 32'h0000_5555;
    model_sin = 32'h0000_6666;
    set_angle(0, 32'h70);
    req_valid = 4'b1001;
    #1;
    check("rmo_req_ready_0", req_ready, 4'b0001);
    @(negedge aclk);
    check("rmo_regrant_start", core_start, 1);
    check("rmo_regrant_id", grant_id, 0);
    check("rmo_regrant_angle", core_angle, 32'h70);
    req_valid = '0;
    wait_rsp("rmo_rsp_seen");
    check("rmo_regrant_rsp", rsp_valid, 4'b0001);
    rsp_ready = 4'b0001;
    @(negedge aclk);
    rsp_ready = '0;

    // ---------------- spurious done in IDLE ----------------
    model_cos   = 32'h0000_dead;
    model_sin   = 32'h0000_beef;
    manual_done = 1'b1;
    @(negedge aclk);
    manual_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      check("sp_idle_busy", busy, 0);
      check("sp_idle_rsp_valid", rsp_valid, 4'b0000);
      check("sp_idle_rsp_cos", rsp_cos, 32'h5555);
    end

    // ---------------- spurious done in RESP ----------------
    model_cos = 32'h0000_7777;
    model_sin = 32'h0000_8888;
    set_angle(1, 32'h21);
    req_valid = 4'b0010;
    wait_rsp("sp_rsp_seen");
    req_valid = '0;
    model_cos   = 32'h0000_dead;
    model_sin   = 32'h0000_beef;
    manual_done = 1'b1;
    @(negedge aclk);
    manual_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      check("sp_resp_valid", rsp_valid, 4'b0010);
      check("sp_resp_cos", rsp_cos, 32'h7777);
      check("sp_resp_sin", rsp_sin, 32'h8888);
      check("sp_resp_err", rsp_err, 0);
    end
    rsp_ready = 4'b0010;
    @(negedge aclk);
    rsp_ready = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      check("sp_after_rsp_valid", rsp_valid, 4'b0000);
      check("sp_after_start", core_start, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
